// File: rtl/tpu_tile_sequencer.sv
// Job sequencer: descriptor FIFO, K-tile split, array start/bank control.
// Optional perf counters when TPU_SEQ_PERF_EN is defined.
module tpu_tile_sequencer #(
  parameter int DEPTH = 4,
  parameter int KT_W  = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  input  logic [KT_W-1:0]        desc_ktiles,
  input  logic [1:0]             desc_act,
  input  logic                   desc_bias_en,
  input  logic                   buf_valid,
  output logic                   buf_release,
  output logic                   core_start,
  output logic                   core_accum,
  output logic                   core_bank,
  output logic                   core_last,
  output logic [1:0]             core_act,
  output logic                   core_bias_en,
  input  logic                   core_done,
  output logic                   job_done,
  output logic                   job_err,
  output logic                   irq,
  input  logic                   irq_clr,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
`ifdef TPU_SEQ_PERF_EN
  ,
  input  logic                   perf_clr,
  output logic [CNT_W-1:0]       perf_total,
  output logic [CNT_W-1:0]       perf_compute,
  output logic [CNT_W-1:0]       perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = KT_W + 3;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_cfg
    $error("tpu_tile_sequencer: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUF,
    ISSUE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  logic [EW-1:0]   head;
  logic [KT_W-1:0] head_k;
  logic [1:0]      head_act;
  logic            head_bias;

  logic [KT_W-1:0] job_k, tile_cnt;
  logic [1:0]      job_act;
  logic            job_bias;
  logic            tile_last, issue_go, run_done;

  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);
  assign push  = desc_valid && !full;

  assign head      = mem[rd_ptr];
  assign head_k    = head[KT_W-1:0];
  assign head_act  = head[KT_W+1:KT_W];
  assign head_bias = head[KT_W+2];

  assign desc_ready = !full;
  assign fifo_level = count;
  assign busy       = (state != IDLE) || !empty;
  assign core_start = (state == ISSUE);

  assign tile_last = (tile_cnt == job_k - KT_W'(1));
  assign issue_go  = (state == WAIT_BUF) && buf_valid;
  assign run_done  = (state == RUN) && core_done;

  // Descriptor storage and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {desc_bias_en, desc_act, desc_ktiles};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and FIFO pop
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_k != '0) state_nxt = WAIT_BUF;
        end
      end
      WAIT_BUF: if (buf_valid) state_nxt = ISSUE;
      ISSUE:    state_nxt = RUN;
      RUN: begin
        if (core_done) state_nxt = core_last ? IDLE : WAIT_BUF;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // Job registers and tile counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_k    <= '0;
      job_act  <= '0;
      job_bias <= 1'b0;
      tile_cnt <= '0;
    end else if (pop) begin
      job_k    <= head_k;
      job_act  <= (head_act == 2'd3) ? 2'd0 : head_act;
      job_bias <= head_bias;
      tile_cnt <= '0;
    end else if (run_done && !core_last) begin
      tile_cnt <= tile_cnt + KT_W'(1);
    end
  end

  // Per-tile array controls, latched on entry to ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_accum   <= 1'b0;
      core_last    <= 1'b0;
      core_act     <= 2'd0;
      core_bias_en <= 1'b0;
    end else if (issue_go) begin
      core_accum   <= (tile_cnt != '0);
      core_last    <= tile_last;
      core_act     <= tile_last ? job_act : 2'd0;
      core_bias_en <= tile_last && job_bias;
    end
  end

  // Completion pulses, bank pointer and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_release <= 1'b0;
      job_done    <= 1'b0;
      job_err     <= 1'b0;
      core_bank   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      buf_release <= run_done;
      job_done    <= run_done && core_last;
      job_err     <= pop && (head_k == '0);
      if (run_done) core_bank <= ~core_bank;
      if (job_done || job_err) irq <= 1'b1;
      else if (irq_clr)        irq <= 1'b0;
    end
  end

`ifdef TPU_SEQ_PERF_EN
  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_total   <= '0;
      perf_compute <= '0;
      perf_stall   <= '0;
    end else if (perf_clr) begin
      perf_total   <= '0;
      perf_compute <= '0;
      perf_stall   <= '0;
    end else begin
      if (busy && !(&perf_total))
        perf_total <= perf_total + CNT_W'(1);
      if ((state == ISSUE || state == RUN) && !(&perf_compute))
        perf_compute <= perf_compute + CNT_W'(1);
      if (state == WAIT_BUF && !(&perf_stall))
        perf_stall <= perf_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Self-checking bench for tpu_tile_sequencer.
// Perf checks are built when TPU_SEQ_PERF_EN is defined.
module tb_tpu_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       desc_valid = 1'b0;
  logic       desc_ready;
  logic [7:0] desc_ktiles = '0;
  logic [1:0] desc_act = '0;
  logic       desc_bias_en = 1'b0;
  logic       buf_valid = 1'b0;
  logic       buf_release, core_start, core_accum, core_bank, core_last;
  logic [1:0] core_act;
  logic       core_bias_en;
  logic       core_done = 1'b0;
  logic       job_done, job_err, irq;
  logic       irq_clr = 1'b0;
  logic       busy;
  logic [2:0] fifo_level;
`ifdef TPU_SEQ_PERF_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_total, perf_compute, perf_stall;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         k;
    logic [1:0] act;
    logic       bias;
  } desc_t;

  desc_t mq[$];
  logic  exp_bank = 1'b0;

  always #5 clk = ~clk;

  tpu_tile_sequencer #(.DEPTH(4), .KT_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ktiles(desc_ktiles), .desc_act(desc_act),
    .desc_bias_en(desc_bias_en),
    .buf_valid(buf_valid), .buf_release(buf_release),
    .core_start(core_start), .core_accum(core_accum),
    .core_bank(core_bank), .core_last(core_last),
    .core_act(core_act), .core_bias_en(core_bias_en),
    .core_done(core_done), .job_done(job_done), .job_err(job_err),
    .irq(irq), .irq_clr(irq_clr), .busy(busy),
    .fifo_level(fifo_level)
`ifdef TPU_SEQ_PERF_EN
    ,
    .perf_clr(perf_clr), .perf_total(perf_total),
    .perf_compute(perf_compute), .perf_stall(perf_stall)
`endif
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic desc_t mk(input int k, input logic [1:0] a,
                               input logic b);
    desc_t d;
    d.k = k;
    d.act = a;
    d.bias = b;
    return d;
  endfunction

  task automatic push_desc(input desc_t d);
    int n;
    desc_valid   = 1'b1;
    desc_ktiles  = 8'(d.k);
    desc_act     = d.act;
    desc_bias_en = d.bias;
    n = 0;
    while (!desc_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("push_timeout", 1, 0);
    step();
    desc_valid = 1'b0;
    mq.push_back(d);
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_clr", irq, 0);
  endtask

  // Acts as loader and array for the oldest queued job.
  task automatic exec_next(input int bwait, input int cdly);
    desc_t d;
    int n;
    logic bad;
    logic [1:0] a;
    d = mq.pop_front();
    a = (d.act == 2'd3) ? 2'd0 : d.act;
    if (d.k == 0) begin
      bad = 1'b0;
      n = 0;
      while (!job_err && n < 6) begin
        step();
        n++;
        if (core_start) bad = 1'b1;
      end
      chk("err_pulse", job_err, 1);
      chk("err_nostart", bad, 0);
      step();
      chk("err_once", job_err, 0);
      chk("err_irq", irq, 1);
      clear_irq();
      return;
    end
    for (int i = 0; i < d.k; i++) begin
      bad = 1'b0;
      for (int j = 0; j < bwait; j++) begin
        core_done = (j == 1);
        step();
        core_done = 1'b0;
        if (core_start) bad = 1'b1;
      end
      chk("hold_nostart", bad, 0);
      buf_valid = 1'b1;
      n = 0;
      do begin
        step();
        n++;
      end while (!core_start && n < 6);
      buf_valid = 1'b0;
      chk("start", core_start, 1);
      if (i > 0 || bwait > 0) chk("start_lat", n, 1);
      chk("accum", core_accum, i != 0);
      chk("last", core_last, i == d.k - 1);
      chk("act", core_act, (i == d.k - 1) ? a : 2'd0);
      chk("bias", core_bias_en, (i == d.k - 1) && d.bias);
      chk("bank", core_bank, exp_bank);
      bad = 1'b0;
      for (int j = 0; j < cdly; j++) begin
        step();
        if (core_start || buf_release || core_bank !== exp_bank ||
            core_last !== (i == d.k - 1)) bad = 1'b1;
      end
      chk("run_stable", bad, 0);
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      exp_bank = ~exp_bank;
      chk("release", buf_release, 1);
      chk("job_done", job_done, i == d.k - 1);
      chk("bank_toggle", core_bank, exp_bank);
    end
    step();
    chk("pulse_end", {buf_release, job_done}, 0);
    chk("irq_set", irq, 1);
    step();
    chk("irq_hold", irq, 1);
    clear_irq();
  endtask

  initial begin
    int n;
    logic bad;
    desc_t d;

    // reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_outs", {buf_release, core_start, core_accum, core_bank,
                     core_last, core_act, core_bias_en, job_done,
                     job_err, irq, busy}, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", desc_ready, 1);
    rst_n = 1'b1;
    step();

    // three-tile job, 5-cycle compute
    push_desc(mk(3, 2'd1, 1'b1));
    exec_next(0, 5);

    // zero-tile job then a normal one
    push_desc(mk(0, 2'd1, 1'b1));
    exec_next(0, 1);
    push_desc(mk(2, 2'd2, 1'b1));
    exec_next(1, 2);

    // long buffer wait with spurious core_done
    push_desc(mk(1, 2'd2, 1'b0));
    exec_next(20, 3);

    // spurious core_done while idle
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    chk("idle_done_ignored",
        {buf_release, job_done, busy, core_start}, 0);

    // fill FIFO while stalled in WAIT_BUF
    push_desc(mk(1, 2'd0, 1'b0));
    step();
    push_desc(mk(2, 2'd1, 1'b0));
    push_desc(mk(1, 2'd3, 1'b1));
    push_desc(mk(1, 2'd2, 1'b1));
    push_desc(mk(2, 2'd1, 1'b1));
    chk("full_level", fifo_level, 4);
    chk("full_ready", desc_ready, 0);
    desc_valid   = 1'b1;
    desc_ktiles  = 8'd1;
    desc_act     = 2'd1;
    desc_bias_en = 1'b1;
    step();
    chk("full_hold", fifo_level, 4);
    exec_next(1, 3);
    desc_valid = 1'b0;
    chk("fifth_accepted", fifo_level, 4);
    mq.push_back(mk(1, 2'd1, 1'b1));
    while (mq.size() > 0) exec_next(1, 2);
    chk("drained", busy, 0);

    // randomized jobs against the queue model
    for (int r = 0; r < 8; r++) begin
      d = mk($urandom_range(0, 4), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      push_desc(d);
      exec_next($urandom_range(0, 3), $urandom_range(1, 6));
    end

    // reset mid-job with queued descriptors
    push_desc(mk(3, 2'd1, 1'b1));
    buf_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!core_start && n < 6);
    buf_valid = 1'b0;
    chk("pre_rst_start", core_start, 1);
    push_desc(mk(2, 2'd0, 1'b0));
    push_desc(mk(1, 2'd2, 1'b1));
    chk("pre_rst_level", fifo_level, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {buf_release, core_start, core_accum, core_bank,
                        core_last, core_act, core_bias_en, job_done,
                        job_err, irq, busy}, 0);
    chk("midrst_level", fifo_level, 0);
    step();
    rst_n = 1'b1;
    mq.delete();
    exp_bank = 1'b0;
    buf_valid = 1'b1;
    bad = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (core_start || busy) bad = 1'b1;
    end
    buf_valid = 1'b0;
    chk("post_rst_quiet", bad, 0);

`ifdef TPU_SEQ_PERF_EN
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr0", perf_total, 0);
    push_desc(mk(1, 2'd0, 1'b0));
    step();
    step();
    step();
    buf_valid = 1'b1;
    step();
    buf_valid = 1'b0;
    chk("perf_start", core_start, 1);
    step();
    step();
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    chk("perf_stall", perf_stall, 3);
    chk("perf_compute", perf_compute, 4);
    chk("perf_total", perf_total, 8);
    void'(mq.pop_front());
    exp_bank = ~exp_bank;
    clear_irq();
    push_desc(mk(1, 2'd0, 1'b0));
    step();
    step();
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr_prio", perf_stall, 0);
    step();
    chk("perf_recount", perf_stall, 1);
    buf_valid = 1'b1;
    step();
    buf_valid = 1'b0;
    step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    step();
    void'(mq.pop_front());
    exp_bank = ~exp_bank;
    clear_irq();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
